// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

endpackage

// File: rtl/rf_read_port.sv
// One registered read port with write-first bypass of the write and clear paths.
module rf_read_port #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] entry_data,
  input  logic              wr_take,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_take,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] read_data
);

  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] data_p1;

  // Write and clear never coincide, so their relative order is irrelevant.
  always_comb begin
    data_p0 = entry_data;
    if (ZERO_R0 && (addr == '0)) begin
      data_p0 = '0;
    end else if (clr_take && (addr == clr_addr)) begin
      data_p0 = '0;
    end else if (wr_take && (addr == wr_addr)) begin
      data_p0 = wr_data;
    end
  end

  // ---- stage p1: registered read data
  always_ff @(posedge clock) begin
    if (reset) begin
      data_p1 <= '0;
    end else begin
      data_p1 <= data_p0;
    end
  end

  assign read_data = data_p1;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two registered write-first read ports and a sequential clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              clear_req,
  output logic              busy
);

  localparam int                DEPTH    = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              wr_take;
  logic              clr_take;

  // Writes are only honoured while idle; entry 0 is read-only when hardwired.
  assign wr_take  = (state == ST_IDLE) && write_enable && !(ZERO_R0 && (write_addr == '0));
  assign clr_take = (state == ST_CLEAR);
  assign busy     = (state == ST_CLEAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_take) begin
        mem[write_addr] <= write_data;
      end
      if (clr_take) begin
        mem[cnt] <= '0;
      end
      unique case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_port1 (
    .clock      (clock),
    .reset      (reset),
    .addr       (read_addr1),
    .entry_data (mem[read_addr1]),
    .wr_take    (wr_take),
    .wr_addr    (write_addr),
    .wr_data    (write_data),
    .clr_take   (clr_take),
    .clr_addr   (cnt),
    .read_data  (read_data1)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_port2 (
    .clock      (clock),
    .reset      (reset),
    .addr       (read_addr2),
    .entry_data (mem[read_addr2]),
    .wr_take    (wr_take),
    .wr_addr    (write_addr),
    .wr_data    (write_data),
    .clr_take   (clr_take),
    .clr_addr   (cnt),
    .read_data  (read_data2)
  );

endmodule
